// File: rtl/seq_loop_monitor_if.sv
// seq_loop_monitor_if: this interface bundles everything that passes between
// the monitored HLS FSM and seq_loop_monitor.
//
// Signals driven by the master (FSM / environment side):
//   cur_state                      live state of the monitored FSM
//   pre_states_valid, pre_loop_state0..2
//                                  states that may precede loop entry
//   post_states_valid, post_loop_state0..3
//                                  states that may follow the loop
//   quit_states_valid, quit_loop_state0..2
//                                  in-loop states that may exit
//   loop_quit_state                exit target state
//   iter_start_state               first state of the loop body
//   iter_end_states_valid, iter_end_state0
//                                  last state of the loop body
//   one_state_loop, one_state_block
//                                  single-state loop body / block shapes
//   finish                         design done
//
// Signals driven by the slave (the monitor):
//   loop_active, loop_enter, iter_start, loop_exit
//   iter_count, trip_count, done, err_pulse, err_code
interface seq_loop_monitor_if #(
  parameter int unsigned FSM_WIDTH = 2,
  parameter int unsigned CNT_WIDTH = 32
);
  logic [FSM_WIDTH-1:0] cur_state;
  logic [2:0]           pre_states_valid;
  logic [FSM_WIDTH-1:0] pre_loop_state0;
  logic [FSM_WIDTH-1:0] pre_loop_state1;
  logic [FSM_WIDTH-1:0] pre_loop_state2;
  logic [3:0]           post_states_valid;
  logic [FSM_WIDTH-1:0] post_loop_state0;
  logic [FSM_WIDTH-1:0] post_loop_state1;
  logic [FSM_WIDTH-1:0] post_loop_state2;
  logic [FSM_WIDTH-1:0] post_loop_state3;
  logic [2:0]           quit_states_valid;
  logic [FSM_WIDTH-1:0] quit_loop_state0;
  logic [FSM_WIDTH-1:0] quit_loop_state1;
  logic [FSM_WIDTH-1:0] quit_loop_state2;
  logic [FSM_WIDTH-1:0] loop_quit_state;
  logic [FSM_WIDTH-1:0] iter_start_state;
  logic                 iter_end_states_valid;
  logic [FSM_WIDTH-1:0] iter_end_state0;
  logic                 one_state_loop;
  logic                 one_state_block;
  logic                 finish;

  logic                 loop_active;
  logic                 loop_enter;
  logic                 iter_start;
  logic                 loop_exit;
  logic [CNT_WIDTH-1:0] iter_count;
  logic [CNT_WIDTH-1:0] trip_count;
  logic                 done;
  logic                 err_pulse;
  logic [1:0]           err_code;

  modport master (
    output cur_state, pre_states_valid, pre_loop_state0, pre_loop_state1, pre_loop_state2,
           post_states_valid, post_loop_state0, post_loop_state1, post_loop_state2,
           post_loop_state3, quit_states_valid, quit_loop_state0, quit_loop_state1,
           quit_loop_state2, loop_quit_state, iter_start_state, iter_end_states_valid,
           iter_end_state0, one_state_loop, one_state_block, finish,
    input  loop_active, loop_enter, iter_start, loop_exit, iter_count, trip_count, done,
           err_pulse, err_code
  );

  modport slave (
    input  cur_state, pre_states_valid, pre_loop_state0, pre_loop_state1, pre_loop_state2,
           post_states_valid, post_loop_state0, post_loop_state1, post_loop_state2,
           post_loop_state3, quit_states_valid, quit_loop_state0, quit_loop_state1,
           quit_loop_state2, loop_quit_state, iter_start_state, iter_end_states_valid,
           iter_end_state0, one_state_loop, one_state_block, finish,
    output loop_active, loop_enter, iter_start, loop_exit, iter_count, trip_count, done,
           err_pulse, err_code
  );
endinterface

// File: rtl/seq_loop_monitor.sv
// seq_loop_monitor: watches the state register of an HLS-generated FSM and
// reports loop entry, loop iterations and loop exit. It also counts iterations
// per trip and the total number of trips, and flags protocol errors.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_loop_monitor_if slave modport. Its inputs are cur_state, the
//          match-set configuration and finish. Its outputs are loop_active,
//          loop_enter, iter_start, loop_exit, iter_count, trip_count, done,
//          err_pulse and err_code.
//
// Events are detected combinationally from the pair (prev_state, cur_state).
// Every output is registered, so a pulse appears in the cycle after the
// cycle in which its event is detected.
module seq_loop_monitor #(
  parameter int unsigned FSM_WIDTH = 2,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  seq_loop_monitor_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IN_LOOP = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_REENTER  = 2'd1;
  localparam logic [1:0] ERR_IDLE_EXIT = 2'd2;
  localparam logic [1:0] ERR_FINISH   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [FSM_WIDTH-1:0] prev_state_q;
  logic                 prev_valid_q;
  logic                 loop_enter_q, loop_enter_d;
  logic                 iter_start_q, iter_start_d;
  logic                 loop_exit_q, loop_exit_d;
  logic [CNT_WIDTH-1:0] iter_count_q, iter_count_d;
  logic [CNT_WIDTH-1:0] trip_count_q, trip_count_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [1:0]           err_new;

  logic in_pre, in_post, in_quit;
  logic back_src, exit_src;
  logic ev_enter, ev_back, ev_exit;

  // Set membership of prev_state / cur_state, qualified by the valid bits.
  assign in_pre = (bus.pre_states_valid[0] && (prev_state_q == bus.pre_loop_state0)) ||
                  (bus.pre_states_valid[1] && (prev_state_q == bus.pre_loop_state1)) ||
                  (bus.pre_states_valid[2] && (prev_state_q == bus.pre_loop_state2));

  assign in_quit = (bus.quit_states_valid[0] && (prev_state_q == bus.quit_loop_state0)) ||
                   (bus.quit_states_valid[1] && (prev_state_q == bus.quit_loop_state1)) ||
                   (bus.quit_states_valid[2] && (prev_state_q == bus.quit_loop_state2));

  assign in_post = (bus.post_states_valid[0] && (bus.cur_state == bus.post_loop_state0)) ||
                   (bus.post_states_valid[1] && (bus.cur_state == bus.post_loop_state1)) ||
                   (bus.post_states_valid[2] && (bus.cur_state == bus.post_loop_state2)) ||
                   (bus.post_states_valid[3] && (bus.cur_state == bus.post_loop_state3));

  // A one-state loop body takes its back-edge from iter_start_state itself.
  assign back_src = bus.one_state_loop ? (prev_state_q == bus.iter_start_state)
                                       : (bus.iter_end_states_valid &&
                                          (prev_state_q == bus.iter_end_state0));

  assign exit_src = in_quit || (bus.one_state_block && (prev_state_q == bus.iter_start_state));

  assign ev_enter = prev_valid_q && in_pre && (bus.cur_state == bus.iter_start_state);
  assign ev_back  = prev_valid_q && back_src && (bus.cur_state == bus.iter_start_state);
  assign ev_exit  = prev_valid_q && exit_src &&
                    ((bus.cur_state == bus.loop_quit_state) || in_post);

  always_comb begin
    state_d      = state_q;
    loop_enter_d = 1'b0;
    iter_start_d = 1'b0;
    loop_exit_d  = 1'b0;
    iter_count_d = iter_count_q;
    trip_count_d = trip_count_q;
    err_new      = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (bus.finish) begin
          state_d = ST_DONE;
        end else begin
          if (ev_exit) err_new = ERR_IDLE_EXIT;
          // ENTER wins over a coincident EXIT; the EXIT is still flagged.
          if (ev_enter) begin
            state_d      = ST_IN_LOOP;
            loop_enter_d = 1'b1;
            iter_start_d = 1'b1;
            iter_count_d = CNT_ONE;
            trip_count_d = (trip_count_q == CNT_MAX) ? trip_count_q : trip_count_q + CNT_ONE;
          end
        end
      end
      ST_IN_LOOP: begin
        if (bus.finish) begin
          state_d = ST_DONE;
          err_new = ERR_FINISH;
        end else begin
          if (ev_enter && !ev_back) err_new = ERR_REENTER;
          if (ev_exit) begin
            state_d     = ST_IDLE;
            loop_exit_d = 1'b1;
          end else if (ev_back) begin
            iter_start_d = 1'b1;
            iter_count_d = (iter_count_q == CNT_MAX) ? iter_count_q : iter_count_q + CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        // Terminal until reset; counts stay frozen.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_pulse_d = (err_new != ERR_NONE);
    // err_code keeps the first error seen since reset.
    err_code_d  = (err_code_q == ERR_NONE) ? err_new : err_code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_state_q <= '0;
      prev_valid_q <= 1'b0;
      loop_enter_q <= 1'b0;
      iter_start_q <= 1'b0;
      loop_exit_q  <= 1'b0;
      iter_count_q <= '0;
      trip_count_q <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      prev_state_q <= bus.cur_state;
      prev_valid_q <= 1'b1;
      loop_enter_q <= loop_enter_d;
      iter_start_q <= iter_start_d;
      loop_exit_q  <= loop_exit_d;
      iter_count_q <= iter_count_d;
      trip_count_q <= trip_count_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.loop_active = (state_q == ST_IN_LOOP);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.loop_enter  = loop_enter_q;
  assign bus.iter_start  = iter_start_q;
  assign bus.loop_exit   = loop_exit_q;
  assign bus.iter_count  = iter_count_q;
  assign bus.trip_count  = trip_count_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Testbench for seq_loop_monitor. It runs two instances (CNT_WIDTH 32 and 4)
// from one shared stimulus and checks both, every cycle, against a
// behavioural model of the loop protocol.
module tb_seq_loop_monitor;
  localparam int unsigned FW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared stimulus.
  logic [FW-1:0] cur_state = '0;
  logic          finish = 1'b0;
  logic [2:0]    pre_v;
  logic [FW-1:0] pre_s [3];
  logic [3:0]    post_v;
  logic [FW-1:0] post_s [4];
  logic [2:0]    quit_v;
  logic [FW-1:0] quit_s [3];
  logic [FW-1:0] quit_tgt, start_s, end_s;
  logic          end_v, osl, osb;

  seq_loop_monitor_if #(.FSM_WIDTH(FW), .CNT_WIDTH(32)) bus_w ();
  seq_loop_monitor_if #(.FSM_WIDTH(FW), .CNT_WIDTH(4))  bus_n ();

  seq_loop_monitor #(.FSM_WIDTH(FW), .CNT_WIDTH(32)) u_dut_w (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_w)
  );
  seq_loop_monitor #(.FSM_WIDTH(FW), .CNT_WIDTH(4)) u_dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n)
  );

  always_comb begin
    bus_w.cur_state = cur_state;            bus_n.cur_state = cur_state;
    bus_w.finish = finish;                  bus_n.finish = finish;
    bus_w.pre_states_valid = pre_v;         bus_n.pre_states_valid = pre_v;
    bus_w.pre_loop_state0 = pre_s[0];       bus_n.pre_loop_state0 = pre_s[0];
    bus_w.pre_loop_state1 = pre_s[1];       bus_n.pre_loop_state1 = pre_s[1];
    bus_w.pre_loop_state2 = pre_s[2];       bus_n.pre_loop_state2 = pre_s[2];
    bus_w.post_states_valid = post_v;       bus_n.post_states_valid = post_v;
    bus_w.post_loop_state0 = post_s[0];     bus_n.post_loop_state0 = post_s[0];
    bus_w.post_loop_state1 = post_s[1];     bus_n.post_loop_state1 = post_s[1];
    bus_w.post_loop_state2 = post_s[2];     bus_n.post_loop_state2 = post_s[2];
    bus_w.post_loop_state3 = post_s[3];     bus_n.post_loop_state3 = post_s[3];
    bus_w.quit_states_valid = quit_v;       bus_n.quit_states_valid = quit_v;
    bus_w.quit_loop_state0 = quit_s[0];     bus_n.quit_loop_state0 = quit_s[0];
    bus_w.quit_loop_state1 = quit_s[1];     bus_n.quit_loop_state1 = quit_s[1];
    bus_w.quit_loop_state2 = quit_s[2];     bus_n.quit_loop_state2 = quit_s[2];
    bus_w.loop_quit_state = quit_tgt;       bus_n.loop_quit_state = quit_tgt;
    bus_w.iter_start_state = start_s;       bus_n.iter_start_state = start_s;
    bus_w.iter_end_states_valid = end_v;    bus_n.iter_end_states_valid = end_v;
    bus_w.iter_end_state0 = end_s;          bus_n.iter_end_state0 = end_s;
    bus_w.one_state_loop = osl;             bus_n.one_state_loop = osl;
    bus_w.one_state_block = osb;            bus_n.one_state_block = osb;
  end

  // Behavioural model. Counts are kept unbounded; each instance's expected
  // value is the unbounded count clipped at its all-ones value.
  int              m_mode;  // 0 idle, 1 in loop, 2 done
  bit              m_pv;
  logic [FW-1:0]   m_prev;
  longint unsigned m_iter, m_trip;
  bit              m_enter, m_istart, m_exit, m_err;
  int              m_code;

  task automatic check_eq(input string tag, input longint unsigned obs,
                          input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint unsigned clip(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pv = 0; m_prev = '0; m_iter = 0; m_trip = 0;
    m_enter = 0; m_istart = 0; m_exit = 0; m_err = 0; m_code = 0;
  endtask

  // Applies one clock edge of protocol rules using the current inputs.
  task automatic model_step();
    bit pre, post, quit, enter, back, leave;
    int code;
    pre = 0; post = 0; quit = 0; code = 0;
    for (int i = 0; i < 3; i++) if (pre_v[i] && m_prev == pre_s[i]) pre = 1;
    for (int i = 0; i < 3; i++) if (quit_v[i] && m_prev == quit_s[i]) quit = 1;
    for (int i = 0; i < 4; i++) if (post_v[i] && cur_state == post_s[i]) post = 1;
    enter = m_pv && pre && cur_state == start_s;
    back  = m_pv && cur_state == start_s &&
            (osl ? (m_prev == start_s) : (end_v && m_prev == end_s));
    leave = m_pv && (quit || (osb && m_prev == start_s)) &&
            (cur_state == quit_tgt || post);
    m_enter = 0; m_istart = 0; m_exit = 0;
    if (m_mode == 2) begin
      // frozen
    end else if (finish) begin
      if (m_mode == 1) code = 3;
      m_mode = 2;
    end else if (m_mode == 0) begin
      if (leave) code = 2;
      if (enter) begin
        m_mode = 1; m_enter = 1; m_istart = 1; m_iter = 1; m_trip++;
      end
    end else begin
      if (enter && !back) code = 1;
      if (leave) begin
        m_mode = 0; m_exit = 1;
      end else if (back) begin
        m_istart = 1; m_iter++;
      end
    end
    m_err = (code != 0);
    if (code != 0 && m_code == 0) m_code = code;
    m_prev = cur_state;
    m_pv = 1;
  endtask

  task automatic check_outputs();
    check_eq("w.loop_active", bus_w.loop_active, m_mode == 1);
    check_eq("w.loop_enter", bus_w.loop_enter, m_enter);
    check_eq("w.iter_start", bus_w.iter_start, m_istart);
    check_eq("w.loop_exit", bus_w.loop_exit, m_exit);
    check_eq("w.iter_count", bus_w.iter_count, clip(m_iter, 64'hFFFF_FFFF));
    check_eq("w.trip_count", bus_w.trip_count, clip(m_trip, 64'hFFFF_FFFF));
    check_eq("w.done", bus_w.done, m_mode == 2);
    check_eq("w.err_pulse", bus_w.err_pulse, m_err);
    check_eq("w.err_code", bus_w.err_code, m_code);
    check_eq("n.loop_active", bus_n.loop_active, m_mode == 1);
    check_eq("n.loop_enter", bus_n.loop_enter, m_enter);
    check_eq("n.iter_start", bus_n.iter_start, m_istart);
    check_eq("n.loop_exit", bus_n.loop_exit, m_exit);
    check_eq("n.iter_count", bus_n.iter_count, clip(m_iter, 15));
    check_eq("n.trip_count", bus_n.trip_count, clip(m_trip, 15));
    check_eq("n.done", bus_n.done, m_mode == 2);
    check_eq("n.err_pulse", bus_n.err_pulse, m_err);
    check_eq("n.err_code", bus_n.err_code, m_code);
  endtask

  // Drive one cycle of stimulus, clock it, check 1 time unit after the edge.
  task automatic step(input logic [FW-1:0] cs, input logic fin);
    cur_state = cs;
    finish = fin;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Drops reset between edges and checks that the outputs clear before any edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic cfg_clear();
    pre_v = '0; post_v = '0; quit_v = '0; end_v = 0; osl = 0; osb = 0;
    for (int i = 0; i < 3; i++) begin pre_s[i] = '0; quit_s[i] = '0; end
    for (int i = 0; i < 4; i++) post_s[i] = '0;
    quit_tgt = '0; start_s = '0; end_s = '0;
  endtask

  // pre0=1, iter_start=2, iter_end0=3, quit0=3, loop_quit=0.
  task automatic cfg_basic();
    cfg_clear();
    pre_v = 3'b001; pre_s[0] = 1; start_s = 2; end_v = 1; end_s = 3;
    quit_v = 3'b001; quit_s[0] = 3; quit_tgt = 0;
  endtask

  task automatic cfg_random();
    pre_v = 3'($urandom); post_v = 4'($urandom); quit_v = 3'($urandom);
    for (int i = 0; i < 3; i++) begin pre_s[i] = FW'($urandom); quit_s[i] = FW'($urandom); end
    for (int i = 0; i < 4; i++) post_s[i] = FW'($urandom);
    quit_tgt = FW'($urandom); start_s = FW'($urandom); end_s = FW'($urandom);
    end_v = 1'($urandom); osl = ($urandom_range(0, 3) == 0); osb = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_basic();
    #3;
    check_outputs();  // reset state with reset held low
    rst_n = 1'b1;

    // Basic loop: 1,2,3,2,3,0.
    step(1, 0);
    step(2, 0);
    check_eq("t1.enter_after_2", bus_w.loop_enter, 1);
    step(3, 0); step(2, 0); step(3, 0); step(0, 0);
    check_eq("t1.exit", bus_w.loop_exit, 1);
    step(0, 0);
    check_eq("t1.iter_count", bus_w.iter_count, 2);
    check_eq("t1.trip_count", bus_w.trip_count, 1);

    // One-state loop: 1,2,2,2,2,0 with quit0=2.
    apply_reset();
    cfg_basic(); osl = 1; quit_s[0] = 2;
    step(1, 0); step(2, 0); step(2, 0); step(2, 0); step(2, 0); step(0, 0);
    check_eq("t2.exit", bus_w.loop_exit, 1);
    check_eq("t2.no_iter_on_exit", bus_w.iter_start, 0);
    check_eq("t2.iter_count", bus_w.iter_count, 4);

    // Saturation: 20 back-edges.
    apply_reset();
    cfg_basic();
    step(1, 0); step(2, 0);
    for (int i = 0; i < 20; i++) begin step(3, 0); step(2, 0); end
    check_eq("t3.iter_sat4", bus_n.iter_count, 15);
    check_eq("t3.iter_w", bus_w.iter_count, 21);
    step(3, 0); step(0, 0);
    check_eq("t3.iter_held", bus_n.iter_count, 15);

    // EXIT while idle, then finish mid-loop.
    apply_reset();
    cfg_basic();
    step(3, 0); step(0, 0);
    check_eq("t4.err_pulse1", bus_w.err_pulse, 1);
    check_eq("t4.err_code1", bus_w.err_code, 2);
    step(1, 0); step(2, 0); step(3, 0); step(2, 1);
    check_eq("t4.err_pulse2", bus_w.err_pulse, 1);
    check_eq("t4.err_code2", bus_w.err_code, 2);
    check_eq("t4.done", bus_w.done, 1);
    step(3, 0); step(2, 0); step(1, 0); step(2, 0); step(3, 0); step(0, 0);
    check_eq("t4.iter_frozen", bus_w.iter_count, 1);
    check_eq("t4.trip_frozen", bus_w.trip_count, 1);
    check_eq("t4.done_held", bus_w.done, 1);

    // Reset mid-loop, then a fresh entry.
    apply_reset();
    cfg_basic();
    step(1, 0); step(2, 0); step(3, 0); step(2, 0);
    check_eq("t5.active", bus_w.loop_active, 1);
    apply_reset();
    check_eq("t5.iter_clear", bus_w.iter_count, 0);
    step(1, 0); step(2, 0);
    check_eq("t5.trip_count", bus_w.trip_count, 1);

    // ENTER and EXIT together in IDLE: ENTER taken, code 2 flagged.
    apply_reset();
    cfg_basic(); pre_v = 3'b011; pre_s[1] = 3; post_v = 4'b0001; post_s[0] = 2;
    step(3, 0); step(2, 0);
    check_eq("t6.enter", bus_w.loop_enter, 1);
    check_eq("t6.err_code", bus_w.err_code, 2);

    // Re-entry from PRE while in the loop: code 1.
    apply_reset();
    cfg_basic(); quit_v = '0;
    step(1, 0); step(2, 0); step(1, 0); step(2, 0);
    check_eq("t7.err_pulse", bus_w.err_pulse, 1);
    check_eq("t7.err_code", bus_w.err_code, 1);

    // Randomized runs.
    for (int blk = 0; blk < 12; blk++) begin
      apply_reset();
      cfg_random();
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 199) == 0) apply_reset();
        step(FW'($urandom), ($urandom_range(0, 149) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
